// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a write FIFO in front of the serialiser.
//
// Frames are start bit (0), DATA_BITS payload bits LSB first, an optional parity
// bit and one or two stop bits (1). Every bit lasts OVERSAMPLING baudpulse_in
// ticks. Frames are sent back-to-back while the FIFO holds data. The parity mode
// and stop-bit count are sampled at each frame start.
//
// Optional feature (macro UART_TX_CTS_EN): adds cts_n_in, an active-low
// clear-to-send input through a 2-flop synchroniser. It gates frame starts only;
// a frame already in progress always completes.
//
// Ports:
//   sysclk_in       system clock, rising edge
//   rst_in          asynchronous active-high reset
//   baudpulse_in    one-cycle oversampling tick
//   wr_valid_in     write request
//   wr_data_in      write data (DATA_BITS)
//   wr_ready_out    FIFO not full (registered)
//   parity_mode_in  00 none, 01 even, 10 odd, 11 none
//   stop2_in        0 = one stop bit, 1 = two stop bits
//   cts_n_in        clear-to-send, active low (UART_TX_CTS_EN only)
//   tx_serial_out   serial line, idles high
//   tx_busy_out     frame activity, stays high across back-to-back frames
//   tx_done_out     one-cycle pulse at the end of each frame
//   fifo_count_out  FIFO occupancy
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned OVERSAMPLING = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          sysclk_in,
    input  logic                          rst_in,
    input  logic                          baudpulse_in,
    input  logic                          wr_valid_in,
    input  logic [DATA_BITS-1:0]          wr_data_in,
    output logic                          wr_ready_out,
    input  logic [1:0]                    parity_mode_in,
    input  logic                          stop2_in,
`ifdef UART_TX_CTS_EN
    input  logic                          cts_n_in,
`endif
    output logic                          tx_serial_out,
    output logic                          tx_busy_out,
    output logic                          tx_done_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLING);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    // ready_q is low whenever the FIFO is full, so a pop in the same cycle
    // never lets a write through.
    assign push = wr_valid_in & ready_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_in;
        end
    end

    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != COUNT_FULL);
        end
    end

    // ---------------------------------------------------------------- CTS
    logic cts_ok;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    // Resets to "not clear" so nothing starts until CTS is seen low.
    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n_in};
        end
    end

    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    // ---------------------------------------------------------------- FSM
    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_second_q, stop_second_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick_end;
    logic                 can_start;
    logic                 start_frame;

    assign tick_end  = baudpulse_in && (tick_q == TICK_LAST);
    assign can_start = (count_q != '0) && cts_ok;

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        stop_second_d = stop_second_q;
        shift_d       = shift_q;
        par_en_d      = par_en_q;
        par_bit_d     = par_bit_q;
        stop2_d       = stop2_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pop           = 1'b0;
        start_frame   = 1'b0;

        if (state_q != StIdle && baudpulse_in) begin
            tick_d = tick_end ? '0 : tick_q + TICK_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (baudpulse_in && can_start) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (tick_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick_end) begin
                    if (bit_q == BIT_LAST) begin
                        stop_second_d = 1'b0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tick_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (tick_end) begin
                    if (stop2_q && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (can_start) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Frame start: pop the head word and latch this frame's configuration.
        if (start_frame) begin
            pop       = 1'b1;
            state_d   = StStart;
            tick_d    = '0;
            shift_d   = head;
            par_en_d  = (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
            par_bit_d = (^head) ^ (parity_mode_in == 2'b10);
            stop2_d   = stop2_in;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            bit_q         <= '0;
            stop_second_q <= 1'b0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            stop_second_q <= stop_second_d;
            shift_q       <= shift_d;
            par_en_q      <= par_en_d;
            par_bit_q     <= par_bit_d;
            stop2_q       <= stop2_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign tx_serial_out  = tx_q;
    assign tx_busy_out    = busy_q;
    assign tx_done_out    = done_q;
    assign wr_ready_out   = ready_q;
    assign fifo_count_out = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DATA_BITS=8, OVERSAMPLING=8, FIFO_DEPTH=16).
// A monitor records the line at every baud tick; a frame decoder rebuilds words,
// parity bits, idle gaps and frame lengths from those samples.
module tb_uart_tx_fifo;

    localparam int DB    = 8;
    localparam int OS    = 8;
    localparam int DEPTH = 16;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       baud = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic [1:0] pmode = 2'b00;
    logic       stop2 = 1'b0;
    logic       cts_n = 1'b0;
    logic       tx, busy, done;
    logic [4:0] count;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_fifo #(
        .DATA_BITS   (DB),
        .OVERSAMPLING(OS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sysclk_in     (sysclk),
        .rst_in        (rst),
        .baudpulse_in  (baud),
        .wr_valid_in   (wr_valid),
        .wr_data_in    (wr_data),
        .wr_ready_out  (wr_ready),
        .parity_mode_in(pmode),
        .stop2_in      (stop2),
`ifdef UART_TX_CTS_EN
        .cts_n_in      (cts_n),
`endif
        .tx_serial_out (tx),
        .tx_busy_out   (busy),
        .tx_done_out   (done),
        .fifo_count_out(count)
    );

    always #5 sysclk = ~sysclk;

    // Baud ticks: random when enabled, otherwise forced by the test.
    bit baud_en = 1'b1;
    bit baud_manual = 1'b0;
    initial forever begin
        @(posedge sysclk);
        #2;
        baud = baud_en ? ($urandom_range(0, 1) == 1) : baud_manual;
    end

    // Monitor.
    bit         mon_clear = 1'b0;
    logic       samples[$];
    int         done_idx[$];
    logic       done_busy[$];
    int         done_cnt = 0;
    int         busy_falls = 0;
    int         zero_samples = 0;
    logic       busy_prev = 1'b0;

    initial forever begin
        @(negedge sysclk);
        if (mon_clear) begin
            samples.delete();
            done_idx.delete();
            done_busy.delete();
            done_cnt = 0;
            busy_falls = 0;
            zero_samples = 0;
            busy_prev = busy;
        end else if (!rst) begin
            if (done === 1'b1) begin
                done_cnt++;
                done_idx.push_back(samples.size());
                done_busy.push_back(busy);
            end
            if (busy_prev === 1'b1 && busy === 1'b0) busy_falls++;
            busy_prev = busy;
            if (tx === 1'b0) zero_samples++;
            if (baud) samples.push_back(tx);
        end
    end

    // Decoder results.
    logic [7:0] dec_words[$];
    logic       dec_par[$];
    int         dec_gaps[$];
    int         dec_start[$];
    int         dec_bad;
    logic [7:0] exp_words[$];

    task automatic decode(input int pbits, input int sbits);
        int i, n, nb, run;
        logic v;
        logic [7:0] w;
        dec_words.delete(); dec_par.delete(); dec_gaps.delete(); dec_start.delete();
        dec_bad = 0;
        n = samples.size();
        nb = 1 + DB + pbits + sbits;
        run = -1;
        i = 0;
        while (i < n) begin
            if (samples[i] === 1'b1) begin
                i++;
                if (run >= 0) run++;
            end else if (i + OS * nb > n) begin
                dec_bad++;
                i = n;
            end else begin
                if (run >= 0) dec_gaps.push_back(run);
                dec_start.push_back(i);
                w = '0;
                for (int s = 0; s < nb; s++) begin
                    v = samples[i + s * OS];
                    for (int k = 1; k < OS; k++)
                        if (samples[i + s * OS + k] !== v) dec_bad++;
                    if (s >= 1 && s <= DB) w[s-1] = v;
                    else if (pbits == 1 && s == DB + 1) dec_par.push_back(v);
                    else if (s > DB + pbits && v !== 1'b1) dec_bad++;
                end
                dec_words.push_back(w);
                i += OS * nb;
                run = 0;
            end
        end
    endtask

    task automatic clear_mon();
        @(posedge sysclk);
        #1 mon_clear = 1'b1;
        @(negedge sysclk);
        #1 mon_clear = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sysclk);
    endtask

    task automatic push_word(input logic [7:0] w);
        @(posedge sysclk);
        #1;
        wr_valid = 1'b1;
        wr_data = w;
        exp_words.push_back(w);
    endtask

    task automatic end_write();
        @(posedge sysclk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            @(posedge sysclk);
            c++;
        end
        vectors++;
        if (done_cnt < n) begin
            miscompares++;
            $display("FAIL wait_done: got %0d pulses, want %0d", done_cnt, n);
        end
    endtask

    // Checks one isolated frame: word, parity, length, done/busy behaviour.
    task automatic check_single(input string name, input logic [7:0] w, input int p, input int s,
                                input logic par);
        decode(p, s);
        vectors++;
        if (dec_words.size() != 1 || dec_bad != 0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s frames: got %0d words %0d bad %0d dones, want 1 0 1", name,
                     dec_words.size(), dec_bad, done_cnt);
        end else begin
            vectors++;
            if (dec_words[0] !== w) begin
                miscompares++;
                $display("FAIL %s data: got %h want %h", name, dec_words[0], w);
            end
            vectors++;
            if (done_idx[0] - dec_start[0] != OS * (1 + DB + p + s)) begin
                miscompares++;
                $display("FAIL %s length: got %0d want %0d", name,
                         done_idx[0] - dec_start[0], OS * (1 + DB + p + s));
            end
            vectors++;
            if (done_busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy_at_done: got %b want 0", name, done_busy[0]);
            end
            if (p == 1) begin
                vectors++;
                if (dec_par.size() != 1 || dec_par[0] !== par) begin
                    miscompares++;
                    $display("FAIL %s parity: got %0d bits, want bit %b", name,
                             dec_par.size(), par);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        #1;
        vectors++;
        if ({tx, busy, done, wr_ready, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL reset: got tx%b busy%b done%b rdy%b cnt%0d, want 1 0 0 1 0",
                     tx, busy, done, wr_ready, count);
        end
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_single();
        pmode = 2'b00;
        stop2 = 1'b0;
        clear_mon();
        push_word(8'hA5);
        end_write();
        wait_done(1, 3000);
        wait_cycles(10);
        check_single("single", 8'hA5, 0, 1, 1'b0);
    endtask

    task automatic test_parity();
        for (int m = 1; m <= 2; m++) begin
            pmode = 2'(m);
            stop2 = 1'b0;
            clear_mon();
            push_word(8'h07);
            end_write();
            wait_done(1, 3000);
            wait_cycles(10);
            check_single(m == 1 ? "parity_even" : "parity_odd", 8'h07, 1, 1, m == 1);
        end
    endtask

    // Random frames with the configuration scrambled once the frame is running.
    task automatic test_random_config();
        logic [7:0] w;
        logic [1:0] m;
        logic s2;
        int p, c;
        for (int it = 0; it < 6; it++) begin
            w = 8'($urandom);
            m = 2'($urandom_range(0, 3));
            s2 = ($urandom_range(0, 1) == 1);
            p = (m == 2'b01 || m == 2'b10) ? 1 : 0;
            pmode = m;
            stop2 = s2;
            clear_mon();
            push_word(w);
            end_write();
            c = 0;
            while (busy !== 1'b1 && c < 500) begin
                @(posedge sysclk);
                c++;
            end
            #1;
            pmode = 2'($urandom);
            stop2 = ~s2;
            wait_done(1, 3000);
            wait_cycles(10);
            check_single("random", w, p, s2 ? 2 : 1, (^w) ^ (m == 2'b10));
        end
    endtask

    task automatic test_back_to_back();
        int ones;
        baud_en = 1'b0;
        baud_manual = 1'b0;
        pmode = 2'b00;
        stop2 = 1'b1;
        exp_words.delete();
        clear_mon();
        for (int i = 0; i < DEPTH; i++) push_word(8'($urandom));
        end_write();
        @(negedge sysclk);
        vectors++;
        if (wr_ready !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL b2b_full: got rdy%b cnt%0d, want rdy0 cnt16", wr_ready, count);
        end
        baud_en = 1'b1;
        wait_done(DEPTH, 20000);
        wait_cycles(10);
        decode(0, 2);
        vectors++;
        if (dec_words.size() != DEPTH || dec_bad != 0 || done_cnt != DEPTH) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d words %0d bad %0d dones, want 16 0 16",
                     dec_words.size(), dec_bad, done_cnt);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (dec_words[i] !== exp_words[i] || done_idx[i] - dec_start[i] != OS * 11) begin
                    miscompares++;
                    $display("FAIL b2b_word%0d: got %h len %0d, want %h len %0d", i,
                             dec_words[i], done_idx[i] - dec_start[i], exp_words[i], OS * 11);
                end
            end
            for (int i = 0; i < DEPTH - 1; i++) begin
                vectors++;
                if (dec_gaps[i] != 0) begin
                    miscompares++;
                    $display("FAIL b2b_gap%0d: got %0d idle ticks want 0", i, dec_gaps[i]);
                end
            end
            ones = 0;
            foreach (done_busy[i]) if (done_busy[i] === 1'b1) ones++;
            vectors++;
            if (busy_falls != 1 || ones != DEPTH - 1 || done_busy[DEPTH-1] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_busy: got falls %0d high_at_done %0d, want 1 15",
                         busy_falls, ones);
            end
        end
    endtask

    task automatic test_full_plus_pop();
        logic [7:0] x, y;
        x = 8'h5A;
        y = 8'hC3;
        baud_en = 1'b0;
        baud_manual = 1'b0;
        pmode = 2'b00;
        stop2 = 1'b0;
        exp_words.delete();
        clear_mon();
        for (int i = 0; i < DEPTH; i++) push_word(8'($urandom));
        @(posedge sysclk);
        #1;
        wr_data = x;
        baud_manual = 1'b1;
        @(negedge sysclk);
        vectors++;
        if (wr_ready !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL fullpop_pre: got rdy%b cnt%0d, want rdy0 cnt16", wr_ready, count);
        end
        @(posedge sysclk);
        #1;
        baud_manual = 1'b0;
        wr_data = y;
        exp_words.push_back(y);
        @(negedge sysclk);
        vectors++;
        if (wr_ready !== 1'b1 || count !== 5'd15) begin
            miscompares++;
            $display("FAIL fullpop_pop: got rdy%b cnt%0d, want rdy1 cnt15", wr_ready, count);
        end
        @(posedge sysclk);
        #1 wr_valid = 1'b0;
        @(negedge sysclk);
        vectors++;
        if (wr_ready !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL fullpop_refill: got rdy%b cnt%0d, want rdy0 cnt16", wr_ready, count);
        end
        baud_en = 1'b1;
        wait_done(DEPTH + 1, 20000);
        wait_cycles(10);
        decode(0, 1);
        vectors++;
        if (dec_words.size() != DEPTH + 1 || dec_bad != 0) begin
            miscompares++;
            $display("FAIL fullpop_frames: got %0d words %0d bad, want 17 0",
                     dec_words.size(), dec_bad);
        end else begin
            for (int i = 0; i <= DEPTH; i++) begin
                vectors++;
                if (dec_words[i] !== exp_words[i]) begin
                    miscompares++;
                    $display("FAIL fullpop_word%0d: got %h want %h", i, dec_words[i],
                             exp_words[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0, c;
        baud_en = 1'b0;
        pmode = 2'b00;
        stop2 = 1'b0;
        exp_words.delete();
        clear_mon();
        push_word(8'($urandom) & 8'hF7);
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        end_write();
        baud_en = 1'b1;
        c = 0;
        while (busy !== 1'b1 && c < 500) begin
            @(negedge sysclk);
            c++;
        end
        n0 = samples.size();
        c = 0;
        while (samples.size() < n0 + OS * 4 + 3 && c < 2000) begin
            @(negedge sysclk);
            c++;
        end
        #1;
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_bit3: got tx%b busy%b, want tx0 busy1", tx, busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({tx, busy, done, wr_ready, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL midrst_async: got tx%b busy%b done%b rdy%b cnt%0d, want 1 0 0 1 0",
                     tx, busy, done, wr_ready, count);
        end
        wait_cycles(3);
        #1 rst = 1'b0;
        clear_mon();
        wait_cycles(400);
        vectors++;
        if (done_cnt != 0 || zero_samples != 0 || busy !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL midrst_after: got dones %0d low_cycles %0d busy%b cnt%0d, want 0 0 0 0",
                     done_cnt, zero_samples, busy, count);
        end
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        logic [2:0] early;
        pmode = 2'b00;
        stop2 = 1'b0;
        cts_n = 1'b1;
        wait_cycles(4);
        clear_mon();
        push_word(8'h3C);
        end_write();
        wait_cycles(200);
        vectors++;
        if (count !== 5'd1 || zero_samples != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cts_blocked: got cnt%0d low_cycles %0d busy%b, want 1 0 0",
                     count, zero_samples, busy);
        end
        baud_en = 1'b0;
        baud_manual = 1'b1;
        @(posedge sysclk);
        #1 cts_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            early[i] = busy;
        end
        @(negedge sysclk);
        vectors++;
        if (early !== 3'b000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cts_start: got early %b busy%b, want 000 1", early, busy);
        end
        wait_cycles(20);
        #1 cts_n = 1'b1;
        baud_en = 1'b1;
        wait_done(1, 3000);
        wait_cycles(10);
        check_single("cts_frame", 8'h3C, 0, 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_random_config();
        test_back_to_back();
        test_full_plus_pop();
        test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the single-byte UART transmitter: 5..9 data bits, runtime parity mode, 1 or 2 stop bits, and a FIFO in front of the serialiser.
- Driven by the shared baud_generator oversampled pulse; frames are sent back-to-back while the FIFO holds data.
- Sits between a CPU/DMA write port and the TX pin.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- OVERSAMPLING, 8, baudpulse_in ticks per bit period; minimum 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
- sysclk_in  input  1  system clock; all logic is on the rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- baudpulse_in  input  1  one-cycle oversampling tick from baud_generator.
- wr_valid_in  input  1  write request.
- wr_data_in  input  DATA_BITS  write data.
- wr_ready_out  output  1  FIFO not full.
- parity_mode_in  input  2  00 none, 01 even, 10 odd, 11 reserved (behaves as none).
- stop2_in  input  1  0 = one stop bit, 1 = two stop bits.
- tx_serial_out  output  1  serial line; idles high.
- tx_busy_out  output  1  high from the frame-start cycle until the last stop bit ends with the FIFO empty.
- tx_done_out  output  1  one-cycle pulse at the end of each frame's final stop bit.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values while rst_in is high, applied asynchronously:
  - tx_serial_out=1, tx_busy_out=0, tx_done_out=0, wr_ready_out=1, fifo_count_out=0.
  - FIFO pointers cleared, FSM in IDLE.
- Reset mid-frame abandons the frame. The line returns high immediately and FIFO contents are discarded.
- FIFO write:
  - A word is pushed on a rising edge when wr_valid_in && wr_ready_out.
  - wr_ready_out = (count != FIFO_DEPTH) and is registered. When full, a write is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: waits until the FIFO is non-empty and baudpulse_in is high. In that cycle it pops the head word into the shift register, latches parity_mode_in and stop2_in, and moves to START.
  - START: line is 0 for OVERSAMPLING ticks, then DATA.
  - DATA: DATA_BITS bits, LSB first, each held for OVERSAMPLING ticks. Then PARITY if the latched mode is 01 or 10, otherwise STOP.
  - PARITY: line = XOR of the data bits (even mode) or its inverse (odd mode), for OVERSAMPLING ticks, then STOP.
  - STOP: line is 1 for OVERSAMPLING ticks (or 2×OVERSAMPLING when the latched stop2 is 1). At the final tick:
    - tx_done_out pulses for one cycle.
    - If the FIFO is non-empty, the FSM pops the next word in that same cycle and goes straight to START (no idle gap). Otherwise it goes to IDLE.
- Timing:
  - The line changes on the cycle after the baudpulse_in tick that ends the previous bit.
  - A tick counter counts 0..OVERSAMPLING-1 on baudpulse_in; sysclk cycles without baudpulse_in never advance it.
  - Frame length in ticks = OVERSAMPLING × (1 + DATA_BITS + P + S), where P is 0 or 1 and S is 1 or 2.
- Configuration changes to parity_mode_in and stop2_in mid-frame have no effect until the next frame start.
- tx_busy_out:
  - Goes high in the cycle the FSM leaves IDLE.
  - Falls in the same cycle as the final tx_done_out when the FIFO is empty.
  - Stays high across back-to-back frames.
- Unused bits above DATA_BITS do not exist; no width padding is sent.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined:
  - Adds port cts_n_in (input, 1, active-low clear-to-send). It passes through a 2-flop synchroniser in this block.
  - The IDLE→START and STOP→START transitions additionally require the synchronised cts_n to be 0.
  - A frame already in progress always completes regardless of cts_n_in.
  - While blocked, the line idles high and tx_busy_out is 0.
- Not defined: the port is absent and frames start on FIFO data alone.

Test Plan:
- Reset then single write:
  - Stimulus: write 8'hA5, DATA_BITS=8, OVERSAMPLING=8, parity none, 1 stop.
  - Required: line shows 0,1,0,1,0,0,1,0,1,1, each 8 ticks; one tx_done_out pulse; tx_busy_out drops with it; decoded value 8'hA5.
- Parity:
  - Stimulus: send 8'h07 with mode 01, then 8'h07 with mode 10.
  - Required: parity bit 1 then 0; frame length 11 bits each.
- Back-to-back:
  - Stimulus: push 16 random words in 16 consecutive cycles (FIFO_DEPTH=16) with stop2_in=1.
  - Required: wr_ready_out low after the 16th write; fifo_count_out reaches 16.
  - Required: all 16 words received in order with exactly 2 stop bits between frames and no idle gap; 16 tx_done_out pulses; tx_busy_out continuously high.
- Full-plus-pop:
  - Stimulus: FIFO full and wr_valid_in held high while a frame start pops.
  - Required: the write in the pop cycle is refused; next cycle wr_ready_out=1 and the write is accepted; count returns to 16.
- Reset mid-frame:
  - Stimulus: assert rst_in during data bit 3 with 4 words queued.
  - Required: tx_serial_out=1 within the same cycle (asynchronous); count=0; no tx_done_out; no frame after release until a new write.
- CTS (UART_TX_CTS_EN defined):
  - Stimulus: hold cts_n_in=1, write 8'h3C.
  - Required: line stays high and count stays 1.
  - Stimulus: drop cts_n_in to 0, then raise it mid-frame.
  - Required: after the drop, the frame starts within 2 cycles plus the next tick; the frame still completes and decodes as 8'h3C.
